afifo_push_arb: RTL and testbench

// - Shares the write (push) port of one async FIFO among R packet sources in the FIFO's write clock domain.
// - Work-conserving round-robin arbiter. A granted source keeps the port until its last beat is accepted.
// - Drives the FIFO push/push_data pins directly and backpressures all sources while the FIFO is full.

---
 rtl/afifo_push_arb_if.sv | 26 ++
 rtl/afifo_push_arb.sv | 185 ++++++++++++++++++
 tb/tb_afifo_push_arb.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_push_arb_if.sv
// afifo_push_arb_if: packet-source and FIFO-push signals for the async FIFO
// write-port arbiter.
//   slave  : the arbiter (accepts beats, drives the FIFO push pins)
//   master : the sources plus the FIFO (drive beats and the full flag)
interface afifo_push_arb_if #(
    parameter int R = 4,
    parameter int W = 32
);
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_last;
    logic [R*W-1:0] req_data;
    logic [R-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_push;
    logic [W-1:0]   fifo_push_data;

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_push, fifo_push_data
    );

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_push, fifo_push_data
    );
endinterface

// File: rtl/afifo_push_arb.sv
// afifo_push_arb: work-conserving round-robin arbiter that shares one async
// FIFO write port among R packet sources. A granted source owns the port
// until its last beat is accepted. The first beat of a packet moves in the
// same cycle it wins arbitration.
// Optional per-requester beat counters: define AFIFO_PUSH_ARB_STATS_EN.
module afifo_push_arb #(
    parameter int R = 4,
    parameter int W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [R-1:0]           cfg_en,
    afifo_push_arb_if.slave        bus,
    output logic                   busy,
    output logic [$clog2(R)-1:0]   grant_id,
    input  logic                   stat_clr,
    output logic [R*16-1:0]        stat_beats
);
    localparam int              ID_W    = $clog2(R);
    localparam logic [ID_W:0]   R_L     = (ID_W+1)'(R);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(R-1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;

    logic [R-1:0]    elig_s;
    logic [ID_W:0]   cand_sum_s;
    logic [ID_W:0]   cand_s;
    logic            hit_s;
    logic            win_found_s;
    logic [ID_W-1:0] win_id_s;

    logic [R-1:0]    ready_s;
    logic            push_s;
    logic [W-1:0]    push_data_s;
    logic [ID_W-1:0] gid_s;
    logic [R-1:0]    ready_out_s;

    // Next requester index with wrap at R (R need not be a power of two).
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        if (id == LAST_ID) begin
            return {ID_W{1'b0}};
        end else begin
            return id + ID_W'(1);
        end
    endfunction

    // Round-robin search: first eligible index at or after rr_ptr, wrapping.
    always_comb begin
        elig_s      = bus.req_valid & cfg_en;
        win_found_s = 1'b0;
        win_id_s    = {ID_W{1'b0}};
        cand_sum_s  = {(ID_W+1){1'b0}};
        cand_s      = {(ID_W+1){1'b0}};
        hit_s       = 1'b0;
        for (int k = 0; k < R; k++) begin
            cand_sum_s  = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            cand_s      = (cand_sum_s >= R_L) ? (cand_sum_s - R_L) : cand_sum_s;
            hit_s       = ~win_found_s & elig_s[cand_s[ID_W-1:0]];
            win_id_s    = hit_s ? cand_s[ID_W-1:0] : win_id_s;
            win_found_s = win_found_s | hit_s;
        end
    end

    // Handshake, push and next-state decode for the IDLE/XFER controller.
    always_comb begin
        ready_s     = {R{1'b0}};
        push_s      = 1'b0;
        push_data_s = {W{1'b0}};
        gid_s       = {ID_W{1'b0}};
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_id_d   = lock_id_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s && !bus.fifo_full) begin
                    ready_s[win_id_s] = 1'b1;
                    push_s            = 1'b1;
                    push_data_s       = bus.req_data[win_id_s*W +: W];
                    gid_s             = win_id_s;
                    if (bus.req_last[win_id_s]) begin
                        rr_ptr_d = next_id(win_id_s);
                    end else begin
                        state_d   = ST_XFER;
                        lock_id_d = win_id_s;
                    end
                end else begin
                    // FIFO full or nobody eligible: hold pointer and state.
                    push_s = 1'b0;
                end
            end
            ST_XFER: begin
                // Only the locked owner is served; cfg_en no longer matters.
                ready_s[lock_id_q] = ~bus.fifo_full;
                push_s             = bus.req_valid[lock_id_q] & ~bus.fifo_full;
                gid_s              = lock_id_q;
                if (push_s) begin
                    push_data_s = bus.req_data[lock_id_q*W +: W];
                    if (bus.req_last[lock_id_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_id(lock_id_q);
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    // Owner bubble or FIFO full: the lock is kept.
                    push_data_s = {W{1'b0}};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, round-robin pointer and locked owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= {ID_W{1'b0}};
            lock_id_q <= {ID_W{1'b0}};
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    // Outputs are forced low while reset is asserted, even though the
    // handshake path is combinational from the request inputs.
    assign ready_out_s        = rst_n ? ready_s : {R{1'b0}};
    assign bus.req_ready      = ready_out_s;
    assign bus.fifo_push      = rst_n & push_s;
    assign bus.fifo_push_data = rst_n ? push_data_s : {W{1'b0}};
    assign busy               = (state_q == ST_XFER);
    assign grant_id           = rst_n ? gid_s : {ID_W{1'b0}};

`ifdef AFIFO_PUSH_ARB_STATS_EN
    logic [15:0]  cnt_q [R];
    logic [R-1:0] acc_s;

    assign acc_s = bus.req_valid & ready_out_s;

    // Saturating per-requester accepted-beat counters; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < R; i++) begin
                cnt_q[i] <= 16'h0000;
            end
        end else if (stat_clr) begin
            for (int i = 0; i < R; i++) begin
                cnt_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < R; i++) begin
                if (acc_s[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'h0001;
                end else begin
                    cnt_q[i] <= cnt_q[i];
                end
            end
        end
    end

    // Flatten the counters onto the statistics bus.
    always_comb begin
        stat_beats = {(R*16){1'b0}};
        for (int i = 0; i < R; i++) begin
            stat_beats[i*16 +: 16] = cnt_q[i];
        end
    end
`else
    logic unused_stat_clr_s;

    assign unused_stat_clr_s = stat_clr;
    assign stat_beats        = {(R*16){1'b0}};
`endif

endmodule

// File: tb/tb_afifo_push_arb.sv
// tb_afifo_push_arb: directed scenarios followed by random traffic, every
// cycle compared against a packet-level model (current owner + rr pointer).
module tb_afifo_push_arb;
    localparam int R    = 4;
    localparam int W    = 32;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [R-1:0]      cfg_en;
    logic              busy;
    logic [ID_W-1:0]   grant_id;
    logic              stat_clr;
    logic [R*16-1:0]   stat_beats;

    afifo_push_arb_if #(.R(R), .W(W)) bus ();

    afifo_push_arb #(.R(R), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_en     (cfg_en),
        .bus        (bus),
        .busy       (busy),
        .grant_id   (grant_id),
        .stat_clr   (stat_clr),
        .stat_beats (stat_beats)
    );

    always #5 clk = ~clk;

    // stimulus
    logic [R-1:0] valid_v;
    logic [R-1:0] last_v;
    logic         full_v;
    int           seq [R];

    // reference model
    int m_owner;   // -1 when no packet is in progress
    int m_rr;
    int m_cnt [R];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int i);
        logic [7:0]  id8;
        logic [23:0] s24;
        id8 = 8'(i);
        s24 = 24'(seq[i]);
        return {id8, s24};
    endfunction

    task automatic drive();
        bus.req_valid = valid_v;
        bus.req_last  = last_v;
        bus.fifo_full = full_v;
        for (int i = 0; i < R; i++) begin
            bus.req_data[i*W +: W] = mk(i);
        end
    endtask

    // One clock: drive, compare combinational outputs, advance the model,
    // then compare the counters after the edge. Starts and ends at negedge.
    task automatic cycle(input int want_gid = -1);
        logic [R-1:0] e_ready;
        logic [R-1:0] elig;
        logic         e_push;
        logic         e_busy;
        logic [W-1:0] e_data;
        logic [63:0]  e_stat;
        int           e_gid;
        int           w;
        drive();
        #1;
        e_ready = '0; e_push = 1'b0; e_busy = 1'b0; e_data = '0; e_gid = 0; w = -1;
        elig = valid_v & cfg_en;
        if (rst_n && m_owner < 0) begin
            if (!full_v) begin
                for (int k = 0; k < R; k++) begin
                    if (w < 0 && elig[(m_rr + k) % R]) w = (m_rr + k) % R;
                end
            end
            if (w >= 0) begin
                e_ready[w] = 1'b1; e_push = 1'b1; e_data = mk(w); e_gid = w;
            end
        end else if (rst_n) begin
            e_busy = 1'b1;
            e_gid  = m_owner;
            e_ready[m_owner] = !full_v;
            e_push = valid_v[m_owner] && !full_v;
            if (e_push) begin
                e_data = mk(m_owner);
                w = m_owner;
            end
        end
        check("req_ready", 64'(bus.req_ready), 64'(e_ready));
        check("fifo_push", 64'(bus.fifo_push), 64'(e_push));
        check("fifo_push_data", 64'(bus.fifo_push_data), 64'(e_data));
        check("busy", 64'(busy), 64'(e_busy));
        if (e_push || e_busy || !rst_n) check("grant_id", 64'(grant_id), 64'(e_gid));
        if (want_gid >= 0) check("grant_dir", 64'(grant_id), 64'(want_gid));

        if (!rst_n) begin
            m_owner = -1;
            m_rr    = 0;
            for (int i = 0; i < R; i++) m_cnt[i] = 0;
        end else begin
            if (stat_clr) begin
                for (int i = 0; i < R; i++) m_cnt[i] = 0;
            end else if (w >= 0 && m_cnt[w] < 65535) begin
                m_cnt[w] = m_cnt[w] + 1;
            end
            if (w >= 0) begin
                seq[w] = seq[w] + 1;
                if (last_v[w]) begin
                    m_owner = -1;
                    m_rr    = (w + 1) % R;
                end else begin
                    m_owner = w;
                end
            end
        end

        @(posedge clk);
        #1;
        e_stat = '0;
`ifdef AFIFO_PUSH_ARB_STATS_EN
        for (int i = 0; i < R; i++) e_stat[i*16 +: 16] = 16'(m_cnt[i]);
`endif
        check("stat_beats", 64'(stat_beats), e_stat);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cfg_en = 4'hF; stat_clr = 1'b0;
        valid_v = 4'h0; last_v = 4'h0; full_v = 1'b0;
        m_owner = -1; m_rr = 0;
        for (int i = 0; i < R; i++) begin
            seq[i] = 0; m_cnt[i] = 0;
        end
        drive();
        @(negedge clk);

        // Reset: requests pending, every output must stay 0.
        valid_v = 4'hF; last_v = 4'hF;
        cycle(0);
        cycle(0);
        rst_n = 1'b1;

        // Single-beat packets from all four: grants rotate 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) cycle(i % R);

        // Req0 single beat moves rr_ptr to 1; then req1 sends 3 beats while
        // req0/req2 are valid, then req2 is granted next.
        valid_v = 4'b0001; last_v = 4'b0001;
        cycle(0);
        valid_v = 4'b0111; last_v = 4'b0101;
        cycle(1);
        cycle(1);
        last_v = 4'b0111;
        cycle(1);
        cycle(2);

        // Req3 three-beat packet with the FIFO full for cycles 2-4.
        valid_v = 4'b1000; last_v = 4'b0000;
        cycle(3);
        full_v = 1'b1;
        cycle(3);
        cycle(3);
        cycle(3);
        full_v = 1'b0;
        cycle(3);
        last_v = 4'b1000;
        cycle(3);

        // Requester 2 disabled: order 0,1,3,0.
        cfg_en = 4'b1011; valid_v = 4'hF; last_v = 4'hF;
        cycle(0);
        cycle(1);
        cycle(3);
        cycle(0);
        cfg_en = 4'hF;

        // Reset pulse in the middle of a req1 packet, with cfg_en dropped
        // for the owner first (packet must keep going).
        valid_v = 4'b0010; last_v = 4'b0000;
        cycle(1);
        cfg_en = 4'b1101;
        cycle(1);
        cfg_en = 4'hF;
        rst_n = 1'b0; valid_v = 4'hF;
        cycle(0);
        rst_n = 1'b1; last_v = 4'hF;
        cycle(0);

        // Statistics: 5 beats from req0, clear, 2 beats, clear during a beat.
        stat_clr = 1'b1; valid_v = 4'b0000;
        cycle();
        stat_clr = 1'b0; valid_v = 4'b0001; last_v = 4'b0001;
        for (int i = 0; i < 5; i++) cycle(0);
`ifdef AFIFO_PUSH_ARB_STATS_EN
        check("stat_five", 64'(stat_beats[15:0]), 64'd5);
`endif
        stat_clr = 1'b1; valid_v = 4'b0000;
        cycle();
`ifdef AFIFO_PUSH_ARB_STATS_EN
        check("stat_clear", 64'(stat_beats[15:0]), 64'd0);
`endif
        stat_clr = 1'b0; valid_v = 4'b0001;
        cycle(0);
        cycle(0);
`ifdef AFIFO_PUSH_ARB_STATS_EN
        check("stat_two", 64'(stat_beats[15:0]), 64'd2);
`endif
        stat_clr = 1'b1;
        cycle(0);
`ifdef AFIFO_PUSH_ARB_STATS_EN
        check("stat_clr_wins", 64'(stat_beats[15:0]), 64'd0);
`endif
        stat_clr = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cfg_en   = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            valid_v  = 4'($urandom_range(0, 15));
            for (int i = 0; i < R; i++) last_v[i] = ($urandom_range(0, 2) == 0);
            full_v   = ($urandom_range(0, 3) == 0);
            stat_clr = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
